// File: rtl/vending_controller_if.sv
// Customer-side bundle for vending_controller: coin/refund/buy/restock inputs, dispense and status outputs.
// Inputs are level-sampled each clock with no backpressure; busy high means buy/refund/coins are being ignored.
interface vending_controller_if #(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W  = 8,
    parameter int SEL_W     = $clog2(NUM_ITEMS)
);
    logic                 nickel;
    logic                 dime;
    logic                 quarter;
    logic                 refund;
    logic                 buy;
    logic [SEL_W-1:0]     item_sel;
    logic                 restock;
    logic                 vend;
    logic                 nickel_out;
    logic                 dime_out;
    logic                 quarter_out;
    logic                 deny;
    logic                 coin_reject;
    logic                 busy;
    logic [CREDIT_W-1:0]  credit;
    logic [NUM_ITEMS-1:0] sold_out;
    logic [1:0]           dbg_state;

    modport master (
        output nickel, dime, quarter, refund, buy, item_sel, restock,
        input  vend, nickel_out, dime_out, quarter_out, deny, coin_reject, busy, credit, sold_out,
        input  dbg_state
    );

    modport slave (
        input  nickel, dime, quarter, refund, buy, item_sel, restock,
        output vend, nickel_out, dime_out, quarter_out, deny, coin_reject, busy, credit, sold_out,
        output dbg_state
    );
endinterface

// File: rtl/vending_controller.sv
// Vending controller: coin credit, priced item purchase, greedy change return (IDLE/VEND/CHANGE).
// Define VEND_STOCK_TRACKING_EN to build per-item stock counters, restock and sold_out flags.
module vending_controller #(
    parameter int NUM_ITEMS  = 4,
    parameter int PRICE_BASE = 50,
    parameter int PRICE_STEP = 25,
    parameter int MAX_CREDIT = 150,
    parameter int CREDIT_W   = 8,
    parameter int INIT_STOCK = 3
) (
    input  logic                clk,
    input  logic                reset,
    vending_controller_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_ITEMS);
    localparam int SUM_W = CREDIT_W + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [SEL_W-1:0]    r_item;
    logic                r_vend;
    logic                r_deny;
    logic                r_coin_reject;
    logic                r_busy;
    logic [2:0]          r_coins;  // {quarter, dime, nickel} change pulses

    logic [SUM_W-1:0]    w_coin_val;
    logic [SUM_W-1:0]    w_sum;
    logic [SUM_W-1:0]    w_price;
    logic [SUM_W-1:0]    w_idle_credit;
    logic                w_coin_ok;
    logic                w_sel_ok;
    logic                w_item_avail;
    logic                w_buy_ok;
    logic [CREDIT_W-1:0] w_change_left;

    function automatic logic [2:0] coin_for(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(25))      return 3'b100;
        else if (c >= CREDIT_W'(10)) return 3'b010;
        else if (c >= CREDIT_W'(5))  return 3'b001;
        else                         return 3'b000;
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [2:0] p);
        return (p[2] ? CREDIT_W'(25) : '0) + (p[1] ? CREDIT_W'(10) : '0) + (p[0] ? CREDIT_W'(5) : '0);
    endfunction

    // Buy is judged on the credit held before this cycle's coins; accepted coins still land.
    always_comb begin
        w_coin_val = (bus.nickel  ? SUM_W'(5)  : '0)
                   + (bus.dime    ? SUM_W'(10) : '0)
                   + (bus.quarter ? SUM_W'(25) : '0);
        w_sum      = SUM_W'(r_credit) + w_coin_val;
        w_coin_ok  = (w_sum <= SUM_W'(MAX_CREDIT));
        w_sel_ok   = ({{(32-SEL_W){1'b0}}, bus.item_sel} < 32'(NUM_ITEMS));
        w_price    = SUM_W'(PRICE_BASE) + SUM_W'(PRICE_STEP) * SUM_W'(bus.item_sel);
        w_buy_ok   = bus.buy && !bus.refund && w_sel_ok && w_item_avail
                   && (SUM_W'(r_credit) >= w_price);
        w_idle_credit = SUM_W'(r_credit);
        if (w_buy_ok) begin
            w_idle_credit = w_idle_credit - w_price;
        end
        if (w_coin_ok) begin
            w_idle_credit = w_idle_credit + w_coin_val;
        end
        w_change_left = r_credit - coin_value(coin_for(r_credit));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_item        <= '0;
            r_vend        <= 1'b0;
            r_deny        <= 1'b0;
            r_coin_reject <= 1'b0;
            r_busy        <= 1'b0;
            r_coins       <= 3'b000;
        end else begin
            r_vend        <= 1'b0;
            r_deny        <= 1'b0;
            r_coin_reject <= 1'b0;
            r_coins       <= 3'b000;
            case (r_state)
                IDLE: begin
                    r_credit      <= CREDIT_W'(w_idle_credit);
                    r_coin_reject <= !w_coin_ok;
                    if (bus.refund) begin
                        if (w_idle_credit != '0) begin
                            r_state <= CHANGE;
                            r_busy  <= 1'b1;
                            r_coins <= coin_for(CREDIT_W'(w_idle_credit));
                        end
                    end else if (w_buy_ok) begin
                        r_state <= VEND;
                        r_busy  <= 1'b1;
                        r_vend  <= 1'b1;
                        r_item  <= bus.item_sel;
                    end else if (bus.buy) begin
                        r_deny <= 1'b1;
                    end
                end
                VEND: begin
                    if (r_credit != '0) begin
                        r_state <= CHANGE;
                        r_coins <= coin_for(r_credit);
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                CHANGE: begin
                    // The coin shown this cycle is paid out now; queue the next one or finish.
                    r_credit <= w_change_left;
                    if (w_change_left == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_coins <= coin_for(w_change_left);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VEND_STOCK_TRACKING_EN
    logic [7:0]           r_stock [NUM_ITEMS];
    logic [NUM_ITEMS-1:0] r_sold_out;

    always_ff @(posedge clk) begin
        if (reset || (r_state == IDLE && bus.restock)) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                r_stock[i] <= 8'(INIT_STOCK);
            end
            r_sold_out <= '0;
        end else if (r_state == VEND) begin
            r_stock[r_item]    <= r_stock[r_item] - 8'd1;
            r_sold_out[r_item] <= (r_stock[r_item] == 8'd1);
        end
    end

    assign w_item_avail = w_sel_ok && !r_sold_out[bus.item_sel];
    assign bus.sold_out = r_sold_out;
`else
    logic             w_unused_restock;
    logic [SEL_W-1:0] w_unused_item;

    assign w_unused_restock = bus.restock;
    assign w_unused_item    = r_item;
    assign w_item_avail     = 1'b1;
    assign bus.sold_out     = '0;
`endif

    assign bus.vend        = r_vend;
    assign bus.quarter_out = r_coins[2];
    assign bus.dime_out    = r_coins[1];
    assign bus.nickel_out  = r_coins[0];
    assign bus.deny        = r_deny;
    assign bus.coin_reject = r_coin_reject;
    assign bus.busy        = r_busy;
    assign bus.credit      = r_credit;
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller: a transaction-level model schedules the expected
// per-cycle outputs, every cycle is compared against it, and literal spot checks pin key values.
module tb_vending_controller;
    localparam int NUM_ITEMS  = 4;
    localparam int PRICE_BASE = 50;
    localparam int PRICE_STEP = 25;
    localparam int MAX_CREDIT = 150;
    localparam int CREDIT_W   = 8;
    localparam int INIT_STOCK = 3;
    localparam int SEL_W      = $clog2(NUM_ITEMS);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vending_controller_if #(.NUM_ITEMS(NUM_ITEMS), .CREDIT_W(CREDIT_W)) bus ();

    vending_controller #(
        .NUM_ITEMS (NUM_ITEMS),
        .PRICE_BASE(PRICE_BASE),
        .PRICE_STEP(PRICE_STEP),
        .MAX_CREDIT(MAX_CREDIT),
        .CREDIT_W  (CREDIT_W),
        .INIT_STOCK(INIT_STOCK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic                 vend;
        logic                 q;
        logic                 d;
        logic                 n;
        logic                 deny;
        logic                 rej;
        logic                 busy;
        logic [CREDIT_W-1:0]  credit;
        logic [NUM_ITEMS-1:0] sold;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_exp;
    bit   m_valid = 1'b0;
    int   m_credit;
    int   m_stock [NUM_ITEMS];

    function automatic logic [NUM_ITEMS-1:0] sold_now();
        logic [NUM_ITEMS-1:0] s = '0;
`ifdef VEND_STOCK_TRACKING_EN
        for (int i = 0; i < NUM_ITEMS; i++) s[i] = (m_stock[i] == 0);
`endif
        return s;
    endfunction

    function automatic exp_t mk(bit vend, bit q, bit d, bit n, bit deny, bit rej, bit busy, int credit);
        exp_t e;
        e.vend   = vend;
        e.q      = q;
        e.d      = d;
        e.n      = n;
        e.deny   = deny;
        e.rej    = rej;
        e.busy   = busy;
        e.credit = CREDIT_W'(credit);
        e.sold   = sold_now();
        return e;
    endfunction

    // Schedule the greedy payout of c cents, one coin per cycle, then the return to idle.
    function automatic void push_change(int c);
        int nq, nd, nn, left;
        nq   = c / 25;
        nd   = (c % 25) / 10;
        nn   = ((c % 25) % 10) / 5;
        left = c;
        for (int i = 0; i < nq; i++) begin exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 1, left)); left -= 25; end
        for (int i = 0; i < nd; i++) begin exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 1, left)); left -= 10; end
        for (int i = 0; i < nn; i++) begin exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 1, left)); left -= 5;  end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    function automatic void model_idle();
        int cv, pre, price;
        bit rej, ok;
        cv    = (bus.nickel ? 5 : 0) + (bus.dime ? 10 : 0) + (bus.quarter ? 25 : 0);
        pre   = m_credit;
        rej   = (pre + cv > MAX_CREDIT);
        if (!rej) m_credit = pre + cv;
        price = PRICE_BASE + int'(bus.item_sel) * PRICE_STEP;
        ok    = (int'(bus.item_sel) < NUM_ITEMS) && (pre >= price) && (m_stock[bus.item_sel] > 0);
`ifdef VEND_STOCK_TRACKING_EN
        if (bus.restock) for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = INIT_STOCK;
`endif
        if (bus.refund) begin
            if (m_credit > 0) begin
                push_change(m_credit);
                m_credit  = 0;
                m_exp     = exp_q.pop_front();
                m_exp.rej = rej;
            end else begin
                m_exp = mk(0, 0, 0, 0, 0, rej, 0, m_credit);
            end
        end else if (bus.buy && ok) begin
            m_credit -= price;
            m_exp = mk(1, 0, 0, 0, 0, rej, 1, m_credit);
`ifdef VEND_STOCK_TRACKING_EN
            m_stock[bus.item_sel] -= 1;
`endif
            push_change(m_credit);
            m_credit = 0;
        end else begin
            m_exp = mk(0, 0, 0, 0, bus.buy, rej, 0, m_credit);
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_credit = 0;
            for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = INIT_STOCK;
            m_exp   = mk(0, 0, 0, 0, 0, 0, 0, 0);
            m_valid = 1'b1;
        end else if (exp_q.size() != 0) begin
            m_exp = exp_q.pop_front();
        end else begin
            model_idle();
        end
    end

    // ---------------- scoreboard / driver ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cnt_vend = 0, cnt_q = 0, cnt_d = 0, cnt_n = 0, cnt_deny = 0, cnt_rej = 0;
    int s_vend, s_q, s_d, s_n, s_deny, s_rej;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic apply(input bit nk, input bit dm, input bit qt, input bit rf, input bit by,
                         input int sel, input bit rstk, input bit rst);
        exp_t act;
        @(negedge clk);
        if (m_valid) begin
            act.vend   = bus.vend;
            act.q      = bus.quarter_out;
            act.d      = bus.dime_out;
            act.n      = bus.nickel_out;
            act.deny   = bus.deny;
            act.rej    = bus.coin_reject;
            act.busy   = bus.busy;
            act.credit = bus.credit;
            act.sold   = bus.sold_out;
            n_checks++;
            if (act !== m_exp) begin
                n_errors++;
                $display("FAIL cycle_model t=%0t act=%h exp=%h", $time, act, m_exp);
            end
            cnt_vend += int'(bus.vend);
            cnt_q    += int'(bus.quarter_out);
            cnt_d    += int'(bus.dime_out);
            cnt_n    += int'(bus.nickel_out);
            cnt_deny += int'(bus.deny);
            cnt_rej  += int'(bus.coin_reject);
        end
        bus.nickel   = nk;
        bus.dime     = dm;
        bus.quarter  = qt;
        bus.refund   = rf;
        bus.buy      = by;
        bus.item_sel = SEL_W'(sel);
        bus.restock  = rstk;
        reset        = rst;
    endtask

    task automatic idle();                          apply(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic ins(input bit nk, dm, qt);       apply(nk, dm, qt, 0, 0, 0, 0, 0); endtask
    task automatic refund_c();                      apply(0, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic buy_c(input int sel);            apply(0, 0, 0, 0, 1, sel, 0, 0); endtask
    task automatic restock_c();                     apply(0, 0, 0, 0, 0, 0, 1, 0); endtask
    task automatic rst_c(input bit v);              apply(0, 0, 0, 0, 0, 0, 0, v); endtask

    task automatic snap();
        s_vend = cnt_vend; s_q = cnt_q; s_d = cnt_d; s_n = cnt_n; s_deny = cnt_deny; s_rej = cnt_rej;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            idle();
            if (!bus.busy) done = 1'b1;
        end
        chk(name, int'(done), 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.nickel = 0; bus.dime = 0; bus.quarter = 0; bus.refund = 0;
        bus.buy = 0; bus.item_sel = '0; bus.restock = 0;
        reset = 1'b1;
        rst_c(1);
        rst_c(1);
        rst_c(0);
        chk("reset_credit", int'(bus.credit), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_sold_out", int'(bus.sold_out), 0);

        // two quarters, buy item 0 at exact price
        ins(0, 0, 1); ins(0, 0, 1); idle();
        chk("two_quarters_credit", int'(bus.credit), 50);
        snap(); buy_c(0); wait_idle("buy0_done");
        chk("buy0_vend_count", cnt_vend - s_vend, 1);
        chk("buy0_no_change", (cnt_q - s_q) + (cnt_d - s_d) + (cnt_n - s_n), 0);
        chk("buy0_credit", int'(bus.credit), 0);

        // 100 cents, buy item 1 (75): vend, one quarter, credit 0 two cycles after vend
        repeat (4) ins(0, 0, 1);
        idle();
        chk("four_quarters_credit", int'(bus.credit), 100);
        buy_c(1);
        idle();
        chk("buy1_vend", int'(bus.vend), 1);
        chk("buy1_vend_credit", int'(bus.credit), 25);
        idle();
        chk("buy1_change_quarter", int'(bus.quarter_out), 1);
        idle();
        chk("buy1_credit_zero", int'(bus.credit), 0);
        chk("buy1_idle", int'(bus.busy), 0);

        // 140 cents, overflowing quarter rejected, then refund 5q+1d+1n
        repeat (5) ins(0, 0, 1);
        ins(0, 1, 0); ins(1, 0, 0); idle();
        chk("credit_140", int'(bus.credit), 140);
        ins(0, 0, 1); idle();
        chk("overflow_reject", int'(bus.coin_reject), 1);
        chk("overflow_credit", int'(bus.credit), 140);
        snap(); refund_c(); wait_idle("refund140_done");
        chk("refund140_q", cnt_q - s_q, 5);
        chk("refund140_d", cnt_d - s_d, 1);
        chk("refund140_n", cnt_n - s_n, 1);

        // deny at 25 cents, same-cycle coins still accepted
        ins(0, 0, 1); idle();
        chk("credit_25", int'(bus.credit), 25);
        apply(1, 1, 1, 0, 1, 0, 0, 0); idle();
        chk("deny_low_credit", int'(bus.deny), 1);
        chk("deny_coins_added", int'(bus.credit), 65);
        refund_c(); wait_idle("refund65_done");

        // credit ceiling exactly reached, nickel rejected, buy most expensive item
        repeat (6) ins(0, 0, 1);
        idle();
        chk("credit_max", int'(bus.credit), MAX_CREDIT);
        ins(1, 0, 0); idle();
        chk("max_nickel_reject", int'(bus.coin_reject), 1);
        snap(); buy_c(3); wait_idle("buy3_done");
        chk("buy3_change_q", cnt_q - s_q, 1);
        chk("buy3_vend", cnt_vend - s_vend, 1);

        // refund and buy with zero credit
        refund_c(); idle();
        chk("refund_zero_idle", int'(bus.busy), 0);
        buy_c(0); idle();
        chk("buy_zero_deny", int'(bus.deny), 1);

        // coins during CHANGE are ignored
        ins(0, 0, 1); ins(0, 0, 1); ins(0, 1, 0);
        snap(); refund_c();
        repeat (3) ins(0, 0, 1);
        wait_idle("busy_coins_done");
        chk("busy_coins_credit", int'(bus.credit), 0);
        chk("busy_coins_q", cnt_q - s_q, 2);
        chk("busy_coins_reject", cnt_rej - s_rej, 0);

        // stock handling on item 2 (100 cents)
`ifdef VEND_STOCK_TRACKING_EN
        for (int k = 0; k < 3; k++) begin
            repeat (4) ins(0, 0, 1);
            buy_c(2);
            wait_idle("stock_buy_done");
        end
        chk("sold_out2_set", int'(bus.sold_out[2]), 1);
        repeat (4) ins(0, 0, 1);
        buy_c(2); idle();
        chk("sold_out_deny", int'(bus.deny), 1);
        chk("sold_out_credit", int'(bus.credit), 100);
        restock_c(); idle();
        chk("restock_clear", int'(bus.sold_out), 0);
        refund_c(); wait_idle("stock_refund_done");
`else
        snap();
        for (int k = 0; k < 4; k++) begin
            repeat (4) ins(0, 0, 1);
            buy_c(2);
            wait_idle("stock_buy_done");
        end
        chk("no_stock_vends", cnt_vend - s_vend, 4);
        restock_c(); idle();
        chk("no_stock_sold_out", int'(bus.sold_out), 0);
`endif

        // reset in the middle of CHANGE with 35 cents
        ins(0, 0, 1); ins(0, 1, 0); refund_c();
        rst_c(1);
        chk("mid_change_credit", int'(bus.credit), 35);
        rst_c(0);
        chk("post_reset_credit", int'(bus.credit), 0);
        chk("post_reset_busy", int'(bus.busy), 0);
        snap();
        repeat (5) idle();
        chk("post_reset_no_coins", (cnt_q - s_q) + (cnt_d - s_d) + (cnt_n - s_n), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
